rr_mux_reg: RTL and testbench
=============================

// Module: rr_mux_reg
//
// PURPOSE
//   Parametrised N:1 multi-bit multiplexer with arbitration and a one-entry output register.
//   N producer channels present valid/data.
//   The block grants one channel per cycle, by round-robin or fixed priority.
//   The granted beat is captured in an output register with a valid/ready handshake.
//   Successor to the fixed 1-bit select-driven mux trees.
//   Used where several datapath sources share one destination, e.g. writeback/bus sharing.
//
// PARAMETERS
//   NUM_CH   8    number of input channels, >= 2
//   WIDTH    64   data width per channel, >= 1
//   MODE     0    0 = round-robin arbitration; 1 = fixed priority (lowest index wins)
//   (derived) SELW = $clog2(NUM_CH)  width of channel index
//
// PORTS
//   clk        in   1              rising-edge clock
//   reset      in   1              asynchronous, active-high reset
//   in_valid   in   NUM_CH         per-channel beat valid
//   in_data    in   NUM_CH*WIDTH   channel c occupies bits [c*WIDTH +: WIDTH]
//   in_ready   out  NUM_CH         one-hot or zero; channel granted this cycle
//   out_valid  out  1              output register holds a beat
//   out_data   out  WIDTH          registered data of the held beat
//   out_ch     out  SELW           index of the channel that produced the held beat
//   out_ready  in   1              consumer accepts the held beat this cycle
//
// BEHAVIOUR
//   Reset (async, immediate): out_valid=0, out_data=0, out_ch=0, rr pointer ptr=0.
//   While reset is high, in_ready=0.
//   Space condition: space = !out_valid | out_ready.
//   Grant (combinational, same cycle):
//     - If space and any in_valid, exactly one in_ready bit is 1: bit g.
//     - Otherwise in_ready = 0.
//   Grant selection:
//     - MODE=0: g = first c with in_valid[c], scanning ptr, ptr+1, ... NUM_CH-1, 0, ... ptr-1.
//     - MODE=1: g = lowest c with in_valid[c]; ptr is unused and stays 0.
//   Transfer: an input beat transfers when in_valid[c] & in_ready[c].
//   At the clock edge after a transfer:
//     - out_valid=1, out_data=in_data[g], out_ch=g.
//     - MODE=0 only: ptr <= (g==NUM_CH-1) ? 0 : g+1.
//   Drain: out_ready & out_valid with no new grant -> out_valid <= 0.
//     - out_data and out_ch hold their last values.
//   Simultaneous drain and grant:
//     - The held beat leaves and the new beat loads in the same edge.
//     - This sustains 1 beat/cycle throughput.
//   Stall: out_valid & !out_ready -> out_data, out_ch and ptr are frozen; in_ready = 0.
//   Latency: 1 cycle from an input transfer to out_valid.
//   Pointer: ptr changes only on a transfer.
//     - Idle cycles and stalls never advance it.
//     - Wrap from NUM_CH-1 to 0 is required for any NUM_CH, including non-powers of 2.
//   Timing path: in_ready depends combinationally on in_valid and out_ready; no ready->valid loop.
//   Producer rule: producers must not drop in_valid or change in_data before their transfer.
//     - The block does not check this.
//   Reset mid-operation: the held beat is discarded; out_valid falls asynchronously; ptr returns to 0.
//   Integer widths: NUM_CH=2 gives SELW=1. Unused index codes cannot be granted.
//
// TESTING
//   1. Reset, all in_valid=0, out_ready=1 -> out_valid=0, in_ready=0 every cycle, ptr=0.
//   2. MODE=0, all 8 valid, out_ready=1 for 16 cycles:
//        out_ch = 0,1,...,7,0,...,7, one per cycle starting 1 cycle after the first grant.
//        out_data[c] = 64'hC0DE_0000_0000_000c.
//   3. MODE=0, only ch5 and ch2 valid, ptr=3 -> ch5 granted first, then ch2, then ch5 (wrap through 7->0).
//   4. Backpressure: out_ready=0 for 4 cycles while ch1 is held:
//        out_data stable, in_ready=0, ptr unchanged.
//        Then out_ready=1 -> next grant in the same cycle, ch1 beat consumed, no beat lost or duplicated.
//   5. MODE=1, ch3 and ch6 valid continuously -> ch3 wins every cycle; ch6 starves.
//        Dropping ch3 -> ch6 is granted the next cycle.
//   6. reset pulsed mid-burst while out_valid=1:
//        out_valid=0 immediately (before the next edge).
//        After release, the first grant follows the scan from ptr=0.
//   Scoreboard: every input transfer appears exactly once at the output, in grant order, with the correct out_ch.
//   Run the bench at NUM_CH=8 and NUM_CH=3.

Source files
------------

// File: rtl/rr_mux_reg_if.sv
// rr_mux_reg_if: producer/consumer bus for the rr_mux_reg arbiter.
//   in_valid  [NUM_CH]        per-channel beat valid          (producers -> mux)
//   in_data   [NUM_CH][WIDTH] per-channel beat data           (producers -> mux)
//   in_ready  [NUM_CH]        one-hot grant, or zero          (mux -> producers)
//   out_valid                 output register holds a beat    (mux -> consumer)
//   out_data  [WIDTH]         held beat data                  (mux -> consumer)
//   out_ch    [SELW]          channel that produced the beat  (mux -> consumer)
//   out_ready                 consumer takes the held beat    (consumer -> mux)
// master = the environment (producers + consumer), slave = the mux.
interface rr_mux_reg_if #(
  parameter int NUM_CH = 8,
  parameter int WIDTH  = 64,
  parameter int SELW   = $clog2(NUM_CH)
);
  logic [NUM_CH-1:0]            in_valid;
  logic [NUM_CH-1:0][WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]            in_ready;
  logic                         out_valid;
  logic [WIDTH-1:0]             out_data;
  logic [SELW-1:0]              out_ch;
  logic                         out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/rr_mux_reg.sv
// rr_mux_reg: N:1 multiplexer with round-robin (MODE=0) or fixed lowest-index
// priority (MODE=1) arbitration and a one-entry output register.
//   clk    rising-edge clock
//   reset  asynchronous, active-high; clears output register and rr pointer
//   bus    rr_mux_reg_if.slave (in_valid/in_data/in_ready, out_valid/out_data/
//          out_ch/out_ready)
// One grant per cycle whenever the output register is empty or being drained,
// so back-to-back beats sustain one transfer per cycle.

// Per-channel request qualifier: channel is at or above the rr pointer.
module rr_mux_reg_lane #(
  parameter int SELW = 3,
  parameter int IDX  = 0
) (
  input  logic            valid,
  input  logic [SELW-1:0] ptr,
  output logic            hi
);
  localparam logic [SELW-1:0] IDX_S = SELW'(IDX);
  assign hi = valid && (IDX_S >= ptr);
endmodule

module rr_mux_reg #(
  parameter int NUM_CH = 8,
  parameter int WIDTH  = 64,
  parameter int MODE   = 0
) (
  input  logic        clk,
  input  logic        reset,
  rr_mux_reg_if.slave bus
);
  localparam int SELW = $clog2(NUM_CH);

  logic [SELW-1:0]   ptr;
  logic [NUM_CH-1:0] hi_req;
  logic [NUM_CH-1:0] req;
  logic [SELW-1:0]   gnt_idx;
  logic              any_req;
  logic              space;
  logic              grant;

  logic              ov_q;
  logic [WIDTH-1:0]  od_q;
  logic [SELW-1:0]   oc_q;

  genvar c;
  for (c = 0; c < NUM_CH; c++) begin : g_lane
    rr_mux_reg_lane #(.SELW(SELW), .IDX(c)) u_lane (
      .valid (bus.in_valid[c]),
      .ptr   (ptr),
      .hi    (hi_req[c])
    );
  end

  // Round-robin as a two-pass priority pick: lowest requester at or above
  // ptr wins; if none, wrap and take the lowest requester overall. This
  // handles any NUM_CH without modulo arithmetic.
  always_comb begin
    space   = !ov_q || bus.out_ready;
    req     = (MODE == 0 && |hi_req) ? hi_req : bus.in_valid;
    gnt_idx = '0;
    any_req = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt_idx = SELW'(i);
        any_req = 1'b1;
      end
    end
    grant        = space && any_req && !reset;
    bus.in_ready = '0;
    for (int i = 0; i < NUM_CH; i++)
      bus.in_ready[i] = grant && (gnt_idx == SELW'(i));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ov_q <= 1'b0;
      od_q <= '0;
      oc_q <= '0;
      ptr  <= '0;
    end else if (grant) begin
      // Covers simultaneous drain + load: the held beat leaves as the new one lands.
      ov_q <= 1'b1;
      od_q <= bus.in_data[gnt_idx];
      oc_q <= gnt_idx;
      if (MODE == 0)
        ptr <= (gnt_idx == SELW'(NUM_CH - 1)) ? '0 : gnt_idx + SELW'(1);
    end else if (bus.out_ready) begin
      // Drain only; data and channel keep their last values.
      ov_q <= 1'b0;
    end
  end

  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;
  assign bus.out_ch    = oc_q;
endmodule

// File: tb/tb_rr_mux_reg.sv
// Bench for rr_mux_reg: three instances (8ch round-robin, 8ch fixed priority,
// 3ch round-robin) checked every cycle against a behavioural model plus a
// grant-order scoreboard, with directed literal checks per scenario.
module tb_rr_mux_reg;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [7:0]       iv   [3];
  logic [7:0][63:0] id   [3];
  logic             ordy [3];
  logic [7:0]       ir   [3];
  logic             ov   [3];
  logic [63:0]      od   [3];
  logic [2:0]       oc   [3];

  int total = 0;
  int bad   = 0;

  rr_mux_reg_if #(.NUM_CH(8), .WIDTH(64)) b0 ();
  rr_mux_reg_if #(.NUM_CH(8), .WIDTH(64)) b1 ();
  rr_mux_reg_if #(.NUM_CH(3), .WIDTH(64)) b2 ();

  rr_mux_reg #(.NUM_CH(8), .WIDTH(64), .MODE(0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
  rr_mux_reg #(.NUM_CH(8), .WIDTH(64), .MODE(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  rr_mux_reg #(.NUM_CH(3), .WIDTH(64), .MODE(0)) dut2 (.clk(clk), .reset(reset), .bus(b2));

  assign b0.in_valid = iv[0];       assign b0.in_data = id[0];       assign b0.out_ready = ordy[0];
  assign b1.in_valid = iv[1];       assign b1.in_data = id[1];       assign b1.out_ready = ordy[1];
  assign b2.in_valid = iv[2][2:0];  assign b2.in_data = id[2][2:0];  assign b2.out_ready = ordy[2];
  assign ir[0] = b0.in_ready;          assign ov[0] = b0.out_valid; assign od[0] = b0.out_data; assign oc[0] = b0.out_ch;
  assign ir[1] = b1.in_ready;          assign ov[1] = b1.out_valid; assign od[1] = b1.out_data; assign oc[1] = b1.out_ch;
  assign ir[2] = {5'b0, b2.in_ready};  assign ov[2] = b2.out_valid; assign od[2] = b2.out_data; assign oc[2] = {1'b0, b2.out_ch};

  function automatic int nch(int k);
    return (k == 2) ? 3 : 8;
  endfunction

  function automatic int mode(int k);
    return (k == 1) ? 1 : 0;
  endfunction

  task automatic chk(string nm, int k, logic [71:0] act, logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %h want %h", nm, k, act, exp);
    end
  endtask

  // Behavioural model: held beat + rr pointer, grant found by scanning
  // channels in order starting at the pointer.
  logic        mv [3];
  logic [63:0] md [3];
  int          mc [3];
  int          mp [3];
  logic [66:0] q0[$], q1[$], q2[$];

  function automatic int mgrant(int k);
    int cc;
    if (mv[k] && !ordy[k]) return -1;
    for (int i = 0; i < nch(k); i++) begin
      cc = (mp[k] + i) % nch(k);
      if (iv[k][cc]) return cc;
    end
    return -1;
  endfunction

  function automatic void qpush(int k, logic [66:0] e);
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic logic [66:0] qpop(int k);
    logic [66:0] e;
    e = '1;
    case (k)
      0: if (q0.size() > 0) e = q0.pop_front();
      1: if (q1.size() > 0) e = q1.pop_front();
      default: if (q2.size() > 0) e = q2.pop_front();
    endcase
    return e;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        mv[k] <= 1'b0; md[k] <= '0; mc[k] <= 0; mp[k] <= 0;
      end
      q0.delete(); q1.delete(); q2.delete();
    end else begin
      for (int k = 0; k < 3; k++) begin
        int g;
        g = mgrant(k);
        if (g >= 0) begin
          mv[k] <= 1'b1;
          md[k] <= id[k][g];
          mc[k] <= g;
          if (mode(k) == 0) mp[k] <= (g + 1) % nch(k);
        end else if (mv[k] && ordy[k]) begin
          mv[k] <= 1'b0;
        end
      end
    end
  end

  // Compare process: outputs vs model every cycle, and scoreboard of grant order.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int g;
      if (reset) begin
        chk("rst_in_ready", k, ir[k], 0);
        chk("rst_out_valid", k, ov[k], 0);
      end else begin
        g = mgrant(k);
        chk("in_ready", k, ir[k], (g >= 0) ? (72'(1) << g) : 72'(0));
        chk("out_valid", k, ov[k], mv[k]);
        if (mv[k]) begin
          chk("out_data", k, od[k], md[k]);
          chk("out_ch", k, oc[k], mc[k]);
        end
        if (ov[k] && ordy[k]) chk("sb_beat", k, {oc[k], od[k]}, qpop(k));
        if (g >= 0) qpush(k, {3'(g), id[k][g]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iv[k] = '0;
      ordy[k] = 1'b1;
      for (int c = 0; c < 8; c++)
        id[k][c] = (k == 2) ? (64'hA5A5_0000_0000_0000 | 64'(c)) : (64'hC0DE_0000_0000_0000 | 64'(c));
    end

    // Reset held with idle inputs
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t1_out_valid", 0, ov[0], 0);
    chk("t1_in_ready", 2, ir[2], 0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk); #1;

    // All 8 valid, round-robin: 0..7,0..7
    iv[0] = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); @(negedge clk);
      chk("t2_ch", 0, oc[0], i % 8);
      chk("t2_data", 0, od[0], 64'hC0DE_0000_0000_0000 | 64'(i % 8));
    end
    @(posedge clk); #1 iv[0] = '0;
    repeat (2) @(posedge clk); #1;

    // Set ptr=3 via a lone ch2 grant, then ch5+ch2: 5,2,5
    iv[0] = 8'h04;
    @(posedge clk); #1 iv[0] = 8'h24;
    @(negedge clk); chk("t3_ch_a", 0, oc[0], 2);
    @(posedge clk); @(negedge clk); chk("t3_ch_b", 0, oc[0], 5);
    @(posedge clk); @(negedge clk); chk("t3_ch_c", 0, oc[0], 2);
    @(posedge clk); @(negedge clk); chk("t3_ch_d", 0, oc[0], 5);
    @(posedge clk); #1 iv[0] = '0;
    repeat (2) @(posedge clk); #1;

    // Backpressure while ch1 is held; ch3 waits
    iv[0] = 8'h02;
    @(posedge clk); #1 begin ordy[0] = 1'b0; iv[0] = 8'h08; end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_hold_ch", 0, oc[0], 1);
      chk("t4_hold_data", 0, od[0], 64'hC0DE_0000_0000_0001);
      chk("t4_stall_ready", 0, ir[0], 0);
    end
    @(posedge clk); #1 ordy[0] = 1'b1;
    @(negedge clk); chk("t4_release_ready", 0, ir[0], 8'h08);
    @(posedge clk); #1 iv[0] = '0;
    @(negedge clk); chk("t4_next_ch", 0, oc[0], 3);
    repeat (2) @(posedge clk); #1;

    // Fixed priority: ch3 starves ch6 until it drops
    iv[1] = 8'h48;
    @(negedge clk); chk("t5_ready", 1, ir[1], 8'h08);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      chk("t5_ch", 1, oc[1], 3);
      chk("t5_ready_hold", 1, ir[1], 8'h08);
    end
    @(posedge clk); #1 iv[1] = 8'h40;
    @(negedge clk); chk("t5_ready6", 1, ir[1], 8'h40);
    @(posedge clk); @(negedge clk); chk("t5_ch6", 1, oc[1], 6);
    @(posedge clk); #1 iv[1] = '0;
    repeat (2) @(posedge clk); #1;

    // 3 channels: wrap 2 -> 0
    iv[2] = 8'h07;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); @(negedge clk);
      chk("t3ch_ch", 2, oc[2], i % 3);
      chk("t3ch_data", 2, od[2], 64'hA5A5_0000_0000_0000 | 64'(i % 3));
    end
    @(posedge clk); #1 iv[2] = '0;
    repeat (2) @(posedge clk); #1;

    // Reset mid-burst
    iv[0] = 8'hFF;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1 chk("t6_async_clear", 0, ov[0], 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk); chk("t6_first_ready", 0, ir[0], 8'h01);
    @(posedge clk); @(negedge clk); chk("t6_first_ch", 0, oc[0], 0);
    @(posedge clk); #1 iv[0] = '0;
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
